// File: rtl/sar_adc_scan_sequencer.sv
// rtl/sar_adc_scan_sequencer.sv - SAR ADC multiplexed channel scan sequencer
// Define SAR_SEQ_TIMEOUT_EN to abort a conversion after TIMEOUT_CYC cycles without eoc.
module sar_adc_scan_sequencer #(
  parameter int N_CH        = 4,
  parameter int N_BITS      = 10,
  parameter int SETTLE_CYC  = 3,
  parameter int TIMEOUT_CYC = 64,
  localparam int CH_W       = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              continuous,
  input  logic [N_CH-1:0]   ch_mask,
  output logic [CH_W-1:0]   adc_ch_sel,
  output logic              adc_hold,
  input  logic              adc_eoc,
  input  logic [N_BITS-1:0] adc_result,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [N_BITS-1:0] res_data,
  output logic [CH_W-1:0]   res_ch,
  output logic              busy,
  output logic              scan_done,
  output logic              timeout_err
);

  localparam int CNT_MAX = (TIMEOUT_CYC > SETTLE_CYC) ? TIMEOUT_CYC : SETTLE_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, SETTLE, CONVERT, OUTPUT} state_e;

  state_e            state_q;
  logic [N_CH-1:0]   mask_q;
  logic [CH_W-1:0]   ch_q, res_ch_q;
  logic [N_BITS-1:0] res_data_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              hold_q, valid_q, busy_q, done_q, terr_q, eoc_q;

  logic [CH_W-1:0]   first_ch_d, next_ch_d, start_ch_d;
  logic              has_next_d, eoc_edge_d, timeout_d, advance_d;

  // Descending scan so the last hit is the lowest qualifying index.
  always_comb begin
    first_ch_d = '0;
    start_ch_d = '0;
    next_ch_d  = '0;
    has_next_d = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (mask_q[i]) first_ch_d = CH_W'(i);
      if (ch_mask[i]) start_ch_d = CH_W'(i);
      if (mask_q[i] && (i > int'(ch_q))) begin
        next_ch_d  = CH_W'(i);
        has_next_d = 1'b1;
      end
    end
  end

  // eoc_q tracks adc_eoc every cycle, so a level already high on CONVERT entry is no edge.
  assign eoc_edge_d = adc_eoc & ~eoc_q;
`ifdef SAR_SEQ_TIMEOUT_EN
  assign timeout_d = (state_q == CONVERT) && !eoc_edge_d && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign timeout_d = 1'b0;
`endif
  assign advance_d = ((state_q == OUTPUT) && res_ready) || timeout_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      mask_q     <= '0;
      ch_q       <= '0;
      res_ch_q   <= '0;
      res_data_q <= '0;
      cnt_q      <= '0;
      hold_q     <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      terr_q     <= 1'b0;
      eoc_q      <= 1'b0;
    end else begin
      eoc_q  <= adc_eoc;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && (ch_mask != '0)) begin
            mask_q  <= ch_mask;
            ch_q    <= start_ch_d;
            terr_q  <= 1'b0;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
            cnt_q   <= '0;
            hold_q  <= 1'b1;
            state_q <= CONVERT;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        CONVERT: begin
          if (eoc_edge_d) begin
            res_data_q <= adc_result;
            res_ch_q   <= ch_q;
            valid_q    <= 1'b1;
            hold_q     <= 1'b0;
            cnt_q      <= '0;
            state_q    <= OUTPUT;
          end
`ifdef SAR_SEQ_TIMEOUT_EN
          else if (timeout_d) begin
            terr_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
`endif
        end
        default: ;
      endcase

      // Shared exit path for a transferred result or an abandoned conversion.
      if (advance_d) begin
        valid_q <= 1'b0;
        hold_q  <= 1'b0;
        cnt_q   <= '0;
        if (has_next_d) begin
          ch_q    <= next_ch_d;
          state_q <= SETTLE;
        end else begin
          done_q <= 1'b1;
          if (continuous) begin
            ch_q    <= first_ch_d;
            state_q <= SETTLE;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
      end
    end
  end

  assign adc_ch_sel  = ch_q;
  assign adc_hold    = hold_q;
  assign res_valid   = valid_q;
  assign res_data    = res_data_q;
  assign res_ch      = res_ch_q;
  assign busy        = busy_q;
  assign scan_done   = done_q;
  assign timeout_err = terr_q;

endmodule
